// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Accelerator indices and sequencer state codes.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned ACC_NTT    = 0;
  localparam int unsigned ACC_PWAM   = 1;
  localparam int unsigned ACC_KECCAK = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_lu.sv
// Load-use hazard detector: an EX load whose rd feeds an ID source.
// Ports: ID sources/use flags, EX rd/mem_read in; lu out.
module pipe_hazard_ctrl_lu #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              mem_read,
  output logic              lu
);

  logic hit1;
  logic hit2;

  assign hit1 = use_rs1 && (rs1 == rd);
  assign hit2 = use_rs2 && (rs2 == rd);
  assign lu   = mem_read && (rd != '0) && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID and ID/EX sequencer: load-use, branch flush, accelerator wait.
// Ports: core_en, ID/EX hazard inputs, acc_done in; stalls, acc_start, status out.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int N_ACC   = 3,
  parameter int TIMEOUT = 1024,
  parameter int TMO_W   = 11,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_en,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic              ID_use_rs1,
  input  logic              ID_use_rs2,
  input  logic [REG_AW-1:0] EX_rd,
  input  logic              EX_mem_read,
  input  logic              EX_branch_taken,
  input  logic              ID_acc_req,
  input  logic [1:0]        ID_acc_sel,
  input  logic [N_ACC-1:0]  acc_done,
  input  logic              stall_clr,
  output logic              CE,
  output logic              PC_stall,
  output logic              IF_ID_dstall,
  output logic              IF_ID_cstall,
  output logic              ID_EX_cstall,
  output logic [N_ACC-1:0]  acc_start,
  output logic              acc_busy,
  output logic              acc_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  hz_state_e        st_q;
  hz_state_e        st_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  logic [1:0]       sel_q;
  logic             tmo_hit;
  logic             hold;
  logic             flush;
  logic             launch;
  logic             lu;
  logic             sel_ok;

  pipe_hazard_ctrl_lu #(
    .REG_AW (REG_AW)
  ) u_lu (
    .rs1      (ID_rs1),
    .rs2      (ID_rs2),
    .use_rs1  (ID_use_rs1),
    .use_rs2  (ID_use_rs2),
    .rd       (EX_rd),
    .mem_read (EX_mem_read),
    .lu       (lu)
  );

  // Out-of-range selects run as ordinary instructions.
  assign sel_ok = 32'(ID_acc_sel) < N_ACC;

  always_comb begin
    st_d    = st_q;
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    launch  = 1'b0;
    unique case (st_q)
      ST_RUN: begin
        if (EX_branch_taken) begin
          flush = 1'b1;
        end else if (lu) begin
          hold = 1'b1;
        end else if (ID_acc_req && sel_ok) begin
          hold   = 1'b1;
          launch = 1'b1;
          tmo_d  = '0;
          st_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        hold = 1'b1;
        if (acc_done[sel_q]) begin
          st_d = ST_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          st_d    = ST_RELEASE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        // Held acc op passes through; acc_req is masked here.
        flush = EX_branch_taken;
        st_d  = ST_RUN;
      end
      default: begin
        st_d = ST_RUN;
      end
    endcase
  end

  assign CE           = core_en;
  assign PC_stall     = hold;
  assign IF_ID_dstall = hold;
  assign IF_ID_cstall = flush;
  assign ID_EX_cstall = hold | flush;
  assign acc_busy     = (st_q == ST_WAIT);
  assign acc_start    = (launch && core_en)
                      ? (N_ACC'(1) << ID_acc_sel)
                      : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= ST_RUN;
      tmo_q       <= '0;
      sel_q       <= '0;
      acc_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else if (core_en) begin
      st_q  <= st_d;
      tmo_q <= tmo_d;
      if (launch) begin
        sel_q <= ID_acc_sel;
      end
      if (tmo_hit) begin
        acc_timeout <= 1'b1;
      end
      if (stall_clr) begin
        stall_cnt <= '0;
      end else if (hold && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int AW  = 5;
  localparam int NA  = 3;
  localparam int TMO = 16;
  localparam int TW  = 5;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_en = 1'b0;
  logic [AW-1:0] ID_rs1 = '0;
  logic [AW-1:0] ID_rs2 = '0;
  logic          ID_use_rs1 = 1'b0;
  logic          ID_use_rs2 = 1'b0;
  logic [AW-1:0] EX_rd = '0;
  logic          EX_mem_read = 1'b0;
  logic          EX_branch_taken = 1'b0;
  logic          ID_acc_req = 1'b0;
  logic [1:0]    ID_acc_sel = '0;
  logic [NA-1:0] acc_done = '0;
  logic          stall_clr = 1'b0;
  logic          CE;
  logic          PC_stall;
  logic          IF_ID_dstall;
  logic          IF_ID_cstall;
  logic          ID_EX_cstall;
  logic [NA-1:0] acc_start;
  logic          acc_busy;
  logic          acc_timeout;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW (AW), .N_ACC (NA), .TIMEOUT (TMO),
    .TMO_W (TW), .CNT_W (CW)
  ) dut (
    .clk (clk), .rst (rst), .core_en (core_en),
    .ID_rs1 (ID_rs1), .ID_rs2 (ID_rs2),
    .ID_use_rs1 (ID_use_rs1), .ID_use_rs2 (ID_use_rs2),
    .EX_rd (EX_rd), .EX_mem_read (EX_mem_read),
    .EX_branch_taken (EX_branch_taken),
    .ID_acc_req (ID_acc_req), .ID_acc_sel (ID_acc_sel),
    .acc_done (acc_done), .stall_clr (stall_clr),
    .CE (CE), .PC_stall (PC_stall),
    .IF_ID_dstall (IF_ID_dstall), .IF_ID_cstall (IF_ID_cstall),
    .ID_EX_cstall (ID_EX_cstall), .acc_start (acc_start),
    .acc_busy (acc_busy), .acc_timeout (acc_timeout),
    .stall_cnt (stall_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: waiting / releasing flags, wait length.
  bit          m_wait;
  bit          m_rel;
  bit          m_tmo;
  int          m_sel;
  int          m_waited;
  longint      m_cnt;
  bit          e_hold;
  bit          e_flush;
  int          e_start;

  function automatic void model_reset();
    m_wait = 0; m_rel = 0; m_tmo = 0;
    m_sel = 0; m_waited = 0; m_cnt = 0;
  endfunction

  function automatic void model_outputs();
    bit lu_e;
    lu_e = EX_mem_read && (EX_rd != 0) &&
           ((ID_use_rs1 && ID_rs1 == EX_rd) ||
            (ID_use_rs2 && ID_rs2 == EX_rd));
    e_hold = 0; e_flush = 0; e_start = 0;
    if (m_wait) e_hold = 1;
    else if (m_rel) e_flush = EX_branch_taken;
    else if (EX_branch_taken) e_flush = 1;
    else if (lu_e) e_hold = 1;
    else if (ID_acc_req && int'(ID_acc_sel) < NA) begin
      e_hold = 1;
      if (core_en) e_start = 1 << ID_acc_sel;
    end
  endfunction

  function automatic void model_next();
    if (!core_en) return;
    if (stall_clr) m_cnt = 0;
    else if (e_hold && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (m_wait) begin
      if (acc_done[m_sel]) begin
        m_wait = 0; m_rel = 1;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_tmo = 1; m_wait = 0; m_rel = 1;
        end
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else if (e_start != 0) begin
      m_wait = 1; m_waited = 0;
      m_sel = int'(ID_acc_sel);
    end
  endfunction

  task automatic settle();
    #2;
    model_outputs();
    chk("ce", 64'(CE), 64'(core_en));
    chk("pc_stall", 64'(PC_stall), 64'(e_hold));
    chk("dstall", 64'(IF_ID_dstall), 64'(e_hold));
    chk("if_cstall", 64'(IF_ID_cstall), 64'(e_flush));
    chk("idex_cstall", 64'(ID_EX_cstall), 64'(e_hold | e_flush));
    chk("acc_start", 64'(acc_start), 64'(e_start));
    chk("acc_busy", 64'(acc_busy), 64'(m_wait));
    chk("acc_timeout", 64'(acc_timeout), 64'(m_tmo));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic idle();
    EX_mem_read = 0; EX_branch_taken = 0; ID_acc_req = 0;
    ID_use_rs1 = 0; ID_use_rs2 = 0; acc_done = '0;
    stall_clr = 0; EX_rd = '0; ID_rs1 = '0; ID_rs2 = '0;
    ID_acc_sel = '0;
  endtask

  task automatic launch(input int sel);
    ID_acc_req = 1; ID_acc_sel = 2'(sel);
  endtask

  initial begin
    model_reset();
    // 1: reset with idle inputs, then run.
    #3;
    settle();
    chk("rst_ce", 64'(CE), 64'd0);
    @(posedge clk); #1;
    rst = 1; core_en = 1;
    cyc();
    chk("run_ce", 64'(CE), 64'd1);

    // 2: load-use on rs2, then rd=0 variant.
    EX_mem_read = 1; EX_rd = 5; ID_rs2 = 5; ID_use_rs2 = 1;
    settle();
    chk("lu_stall", 64'(IF_ID_dstall), 64'd1);
    advance();
    idle(); cyc();
    EX_mem_read = 1; EX_rd = 0; ID_rs2 = 0; ID_use_rs2 = 1;
    settle();
    chk("lu_x0", 64'(IF_ID_dstall), 64'd0);
    advance();
    idle(); stall_clr = 1; cyc();
    stall_clr = 0;

    // 3: KECCAK launch, done 7 cycles later.
    launch(ACC_KECCAK);
    settle();
    chk("t3_start", 64'(acc_start), 64'b100);
    advance();
    for (int i = 0; i < 6; i++) cyc();
    acc_done = 3'b100;
    settle();
    chk("t3_busy", 64'(acc_busy), 64'd1);
    advance();
    acc_done = '0;
    settle();
    chk("t3_rel_stall", 64'(IF_ID_dstall), 64'd0);
    chk("t3_rel_start", 64'(acc_start), 64'd0);
    advance();
    idle();
    settle();
    chk("t3_cnt", 64'(stall_cnt), 64'd8);
    advance();

    // 4: NTT launch with no done -> timeout.
    launch(ACC_NTT);
    for (int i = 0; i < TMO + 1; i++) cyc();
    settle();
    chk("t4_rel_busy", 64'(acc_busy), 64'd0);
    chk("t4_tmo", 64'(acc_timeout), 64'd1);
    advance();
    idle();
    for (int i = 0; i < 3; i++) cyc();
    chk("t4_sticky", 64'(acc_timeout), 64'd1);

    // 5: branch beats acc_req; load-use defers launch.
    launch(ACC_PWAM); EX_branch_taken = 1;
    settle();
    chk("t5_flush", 64'(IF_ID_cstall), 64'd1);
    chk("t5_nostart", 64'(acc_start), 64'd0);
    advance();
    EX_branch_taken = 0; ID_acc_req = 0;
    settle();
    chk("t5_run", 64'(acc_busy), 64'd0);
    advance();
    launch(ACC_PWAM);
    EX_mem_read = 1; EX_rd = 7; ID_rs1 = 7; ID_use_rs1 = 1;
    settle();
    chk("t5_defer", 64'(acc_start), 64'd0);
    advance();
    EX_mem_read = 0;
    settle();
    chk("t5_launch", 64'(acc_start), 64'b010);
    advance();
    acc_done = 3'b010; cyc();
    idle(); cyc(); cyc();

    // 6: foreign done ignored, reset mid-wait.
    launch(ACC_NTT); cyc();
    acc_done = 3'b010; cyc(); cyc();
    chk("t6_ignore", 64'(acc_busy), 64'd1);
    rst = 0;
    #1;
    model_reset();
    settle();
    chk("t6_busy", 64'(acc_busy), 64'd0);
    chk("t6_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1; idle(); cyc();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      core_en         = ($urandom_range(0, 9) != 0);
      EX_rd           = AW'($urandom_range(0, 3));
      ID_rs1          = AW'($urandom_range(0, 3));
      ID_rs2          = AW'($urandom_range(0, 3));
      ID_use_rs1      = $urandom_range(0, 1) == 1;
      ID_use_rs2      = $urandom_range(0, 1) == 1;
      EX_mem_read     = $urandom_range(0, 3) == 0;
      EX_branch_taken = $urandom_range(0, 9) == 0;
      ID_acc_req      = $urandom_range(0, 4) == 0;
      ID_acc_sel      = 2'($urandom_range(0, 3));
      stall_clr       = $urandom_range(0, 49) == 0;
      for (int b = 0; b < NA; b++)
        acc_done[b]   = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 999) == 0) begin
        rst = 0;
        #1;
        model_reset();
        settle();
        @(posedge clk); #1;
        rst = 1;
      end else begin
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
